// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store memory port.
//
// Contents:
//   WORD, WIDTH, ADDR_WIDTH  - bytes per RAM word, bits per byte, RAM byte-address width
//   DATA_W                   - request/RAM data and address width (WORD*WIDTH)
//   FAULT_BOUND              - highest byte address whose 4-byte window fits in the RAM
//   lsu_state_t              - controller states
//   lsu_req_t                - request fields captured at accept
//   addr_fault()             - out-of-range check applied to every request
//   word_misaligned()        - low address bits non-zero, used by the optional
//                              alignment check (macro LSU_ALIGN_CHECK_EN)

package lsu_pkg;

    localparam int WORD       = 4;
    localparam int WIDTH      = 8;
    localparam int ADDR_WIDTH = 10;
    localparam int DATA_W     = WORD * WIDTH;
    localparam int OFFSET_W   = $clog2(WORD);

    // A word window starting above this address would run past the end of the RAM.
    localparam logic [DATA_W-1:0] FAULT_BOUND = DATA_W'((1 << ADDR_WIDTH) - WORD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_RESP
    } lsu_state_t;

    typedef struct packed {
        logic              we;
        logic              byte_op;
        logic              sign_ext;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } lsu_req_t;

    // Byte accesses share the word bound, so the last WORD-1 bytes are unreachable.
    function automatic logic addr_fault(input logic [DATA_W-1:0] addr);
        return (addr[DATA_W-1:ADDR_WIDTH] != '0) || (addr > FAULT_BOUND);
    endfunction

    function automatic logic word_misaligned(input logic [DATA_W-1:0] addr);
        return addr[OFFSET_W-1:0] != '0;
    endfunction

endpackage

// File: rtl/lsu_mem_port_byte_lane.sv
// lsu_byte_lane: combinational byte handling for the load/store port.
//
// Ports:
//   ram_q       in  DATA_W  registered RAM read word; addressed byte in the low lane
//   store_word  in  DATA_W  captured store data; only the low byte is merged
//   sign_ext    in  1       sign-extend the loaded byte when 1, zero-extend when 0
//   load_byte   out DATA_W  extended low byte of ram_q
//   merged_word out DATA_W  ram_q with its low byte replaced by the store byte

module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] ram_q,
    input  logic [DATA_W-1:0] store_word,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] load_byte,
    output logic [DATA_W-1:0] merged_word
);

    localparam logic [DATA_W-1:0] LOW_MASK = DATA_W'((1 << WIDTH) - 1);

    logic [WIDTH-1:0] low_byte;

    // Extract/extend for byte loads and overlay for byte stores. The overlay is
    // written as a mask so the read-modify-write keeps the upper bytes untouched.
    always_comb begin
        low_byte    = ram_q[WIDTH-1:0];
        load_byte   = {{(DATA_W-WIDTH){sign_ext & low_byte[WIDTH-1]}}, low_byte};
        merged_word = (ram_q & ~LOW_MASK) | (store_word & LOW_MASK);
    end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store initiator between the execute stage and a
// byte-addressed word RAM with one-cycle registered read latency.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_we, req_byte         store / byte-access selects
//   req_signed               sign-extend byte loads
//   req_addr, req_wdata      byte address and store data
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata, rsp_fault     load data (0 for stores and faults), rejected access
//   ram_d, ram_ad, ram_we    RAM write data, address, write enable
//   ram_q                    RAM registered read data
//
// Configuration: defining LSU_ALIGN_CHECK_EN makes a word access with a
// non-zero low address offset fault at accept. Without it, unaligned word
// accesses go to the RAM as any 4-byte window.

module lsu_mem_port
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic [DATA_W-1:0] ram_d,
    output logic [DATA_W-1:0] ram_ad,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    lsu_state_t        state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [DATA_W-1:0] ram_d_q, ram_d_d;

    logic              accept_fault;
    logic [DATA_W-1:0] load_byte;
    logic [DATA_W-1:0] merged_word;

    lsu_byte_lane u_byte_lane (
        .ram_q       (ram_q),
        .store_word  (req_q.wdata),
        .sign_ext    (req_q.sign_ext),
        .load_byte   (load_byte),
        .merged_word (merged_word)
    );

    // Fault decision for the request currently offered on the input port.
    always_comb begin
        accept_fault = addr_fault(req_addr);
`ifdef LSU_ALIGN_CHECK_EN
        if (!req_byte && word_misaligned(req_addr)) begin
            accept_fault = 1'b1;
        end
`endif
    end

    // State and datapath registers. A write already presented in WR is sampled
    // by the RAM at the same edge as reset, so it still lands; anything earlier
    // in flight is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
            ram_d_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
            ram_d_q     <= ram_d_d;
        end
    end

    // Next-state and next-datapath logic. ram_d is loaded only on the
    // transition into WR and is zero in every other state.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;
        ram_d_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d = '{we:       req_we,
                              byte_op:  req_byte,
                              sign_ext: req_signed,
                              addr:     req_addr,
                              wdata:    req_wdata};
                    rsp_fault_d = accept_fault;
                    rsp_rdata_d = '0;
                    if (accept_fault) begin
                        state_d = ST_RESP;
                    end else if (req_we && !req_byte) begin
                        state_d = ST_WR;
                        ram_d_d = req_wdata;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Only loads and byte stores pass through here.
                if (req_q.we) begin
                    state_d = ST_WR;
                    ram_d_d = merged_word;
                end else begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = req_q.byte_op ? load_byte : ram_q;
                end
            end
            ST_WR: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and write-enable decode straight from the current state.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        ram_we    = (state_q == ST_WR);
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;
    assign ram_d     = ram_d_q;
    assign ram_ad    = req_q.addr;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: self-checking bench for lsu_mem_port.
//
// A behavioural RAM (byte array, registered read) sits on the RAM port. A
// separate reference byte array tracks what memory should hold; expected load
// data, store words, fault flags and response latencies are derived from it.
// Honours LSU_ALIGN_CHECK_EN when deciding whether an access should fault.

module tb_lsu_mem_port;

`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] ram_d;
    logic [31:0] ram_ad;
    logic        ram_we;
    logic [31:0] ram_q = '0;

    logic [7:0]  ramMem [0:MEM_BYTES-1];
    logic [7:0]  refMem [0:MEM_BYTES-1];

    int assertions;
    int failures;

    lsu_mem_port dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_byte   (req_byte),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .ram_d      (ram_d),
        .ram_ad     (ram_ad),
        .ram_we     (ram_we),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read of the 4-byte window at ram_ad (old data
    // on a simultaneous write), whole-word write when ram_we is high.
    always @(posedge clk) begin : ramModel
        logic [31:0] rd;
        int          base;
        base = int'(ram_ad[9:0]);
        for (int i = 0; i < 4; i++) rd[8*i +: 8] = ramMem[(base + i) % MEM_BYTES];
        ram_q <= rd;
        if (ram_we) begin
            for (int i = 0; i < 4; i++) ramMem[(base + i) % MEM_BYTES] = ram_d[8*i +: 8];
        end
    end

    // Hard stop in case something escapes the per-transaction cycle bounds.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One complete transaction: offer, accept, watch the RAM port, check the
    // response and its latency, optionally stall the response with a competing
    // request offered, then complete the handshake.
    task automatic applyStimulus(input logic we, input logic byt, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int holdCycles, input bit distract,
                                 output logic [31:0] gotRdata, output logic [31:0] gotWeData);
        bit          fault;
        int          a;
        int          expLat;
        int          expWe;
        logic [31:0] expRdata;
        logic [31:0] expWord;
        int          cyc;
        int          weCount;
        int          weCycle;
        logic [31:0] weAd;
        logic [31:0] rdata0;

        // Reference model
        fault    = (addr > 32'd1020) || (ALIGN_CHECK && !byt && addr[1:0] != 2'b00);
        a        = int'(addr[9:0]);
        expRdata = '0;
        expWord  = '0;
        expWe    = 0;
        if (fault) begin
            expLat = 1;
        end else if (we) begin
            expWe = 1;
            if (byt) begin
                expLat  = 4;
                expWord = {refMem[a+3], refMem[a+2], refMem[a+1], wdata[7:0]};
                refMem[a] = wdata[7:0];
            end else begin
                expLat  = 2;
                expWord = wdata;
                for (int i = 0; i < 4; i++) refMem[a+i] = wdata[8*i +: 8];
            end
        end else begin
            expLat = 3;
            if (byt) begin
                if (sgn && refMem[a] >= 8'd128) expRdata = 32'(int'(refMem[a]) - 256);
                else                            expRdata = 32'(refMem[a]);
            end else begin
                expRdata = {refMem[a+3], refMem[a+2], refMem[a+1], refMem[a]};
            end
        end

        @(negedge clk);
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_byte   = byt;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_byte   = 1'($urandom_range(0, 1));
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_wdata  = $urandom;

        cyc       = 1;
        weCount   = 0;
        weCycle   = 0;
        weAd      = '0;
        gotWeData = '0;
        while (cyc <= 20) begin
            @(negedge clk);
            if (ram_we) begin
                weCount++;
                weCycle   = cyc;
                weAd      = ram_ad;
                gotWeData = ram_d;
            end
            if (rsp_valid) break;
            @(posedge clk);
            cyc++;
        end

        checkOutput("rsp_latency", 32'(cyc), 32'(expLat));
        gotRdata = rsp_rdata;
        if (cyc > 20) return;
        checkOutput("rsp_fault", 32'(rsp_fault), 32'(fault));
        checkOutput("rsp_rdata", rsp_rdata, expRdata);
        checkOutput("ram_we_pulses", 32'(weCount), 32'(expWe));
        checkOutput("ram_d_outside_wr", ram_d, 32'd0);
        if (expWe == 1) begin
            checkOutput("ram_we_cycle", 32'(weCycle), 32'(expLat - 1));
            checkOutput("ram_d_word", gotWeData, expWord);
            checkOutput("ram_ad_write", weAd, addr);
        end

        rdata0 = rsp_rdata;
        if (distract) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_byte  = 1'b0;
            req_addr  = 32'h0000_0010;
            req_wdata = 32'hBAD0_BAD0;
        end
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_rsp_rdata", rsp_rdata, rdata0);
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
            checkOutput("hold_ram_we", 32'(ram_we), 32'd0);
        end
        req_valid = 1'b0;

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput("post_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] gotWe;
        int          sel;
        int          hold;
        logic [31:0] raddr;

        assertions = 0;
        failures   = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_byte   = 1'b0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            ramMem[i] = v;
            refMem[i] = v;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] checking reset state");
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        checkOutput("reset_ram_we", 32'(ram_we), 32'd0);
        checkOutput("reset_ram_d", ram_d, 32'd0);
        checkOutput("reset_ram_ad", ram_ad, 32'd0);
        reset = 1'b0;

        $display("[TB] word store then word load");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h010, 32'hDEADBEEF, 0, 1'b0, got, gotWe);
        checkOutput("word_store_data", gotWe, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h010, 32'h0, 0, 1'b0, got, gotWe);
        checkOutput("word_load_data", got, 32'hDEADBEEF);

        $display("[TB] byte store read-modify-write");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h020, 32'h44332211, 0, 1'b0, got, gotWe);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h020, 32'h000000AB, 0, 1'b0, got, gotWe);
        checkOutput("byte_store_merge", gotWe, 32'h443322AB);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h020, 32'h0, 0, 1'b0, got, gotWe);
        checkOutput("byte_store_readback", got, 32'h443322AB);

        $display("[TB] byte loads with and without sign extension");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h030, 32'h12345680, 0, 1'b0, got, gotWe);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h030, 32'h0, 0, 1'b0, got, gotWe);
        checkOutput("byte_load_signed", got, 32'hFFFFFF80);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h030, 32'h0, 0, 1'b0, got, gotWe);
        checkOutput("byte_load_unsigned", got, 32'h00000080);

        $display("[TB] address bound");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h3FD, 32'h0, 0, 1'b0, got, gotWe);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h400, 32'h55AA55AA, 0, 1'b0, got, gotWe);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h3FD, 32'h00000077, 0, 1'b0, got, gotWe);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 0, 1'b0, got, gotWe);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h3FC, 32'hCAFEF00D, 0, 1'b0, got, gotWe);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h3FC, 32'h0, 0, 1'b0, got, gotWe);
        checkOutput("top_word_load", got, 32'hCAFEF00D);

        $display("[TB] response stall with competing request");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h010, 32'h0, 5, 1'b1, got, gotWe);
        checkOutput("stall_load_data", got, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h010, 32'h0, 0, 1'b0, got, gotWe);
        checkOutput("stall_no_write", got, 32'hDEADBEEF);

        $display("[TB] reset during byte store");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'h11223344, 0, 1'b0, got, gotWe);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_byte   = 1'b1;
        req_signed = 1'b0;
        req_addr   = 32'h100;
        req_wdata  = 32'h0000005A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_rd_ram_ad", ram_ad, 32'h100);
        checkOutput("rst_rd_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_wait_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_ram_ad", ram_ad, 32'd0);
        checkOutput("rst_ram_d", ram_d, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_idle_ram_we", 32'(ram_we), 32'd0);
            checkOutput("rst_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 0, 1'b0, got, gotWe);
        checkOutput("rst_no_write", got, 32'h11223344);

        $display("[TB] unaligned word access");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h011, 32'h0, 0, 1'b0, got, gotWe);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h043, 32'h76543210, 0, 1'b0, got, gotWe);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h042, 32'h0, 0, 1'b0, got, gotWe);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 200; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      raddr = $urandom;
            else if (sel == 1) raddr = 32'(1016 + $urandom_range(0, 7));
            else               raddr = 32'($urandom_range(0, 1023));
            hold = int'($urandom_range(0, 2));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), raddr, $urandom, hold,
                          (hold > 0) && ($urandom_range(0, 1) == 1), got, gotWe);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator between the CPU execute stage and the byte-addressed word RAM. It accepts one request at a time over a valid/ready handshake and drives the RAM's data, address and write-enable lines. It retrieves read data after the RAM's one-cycle registered latency and returns a response over a second valid/ready handshake. Byte stores (`strb`) are done as read-modify-write, because the RAM writes only whole words; byte loads (`ldrb`/`ldrsb`) extract and extend the low byte.

## Interface
- `WORD`, 4: bytes per RAM word.
- `WIDTH`, 8: bits per byte.
- `ADDR_WIDTH`, 10: RAM byte-address width; RAM holds 2^ADDR_WIDTH bytes.

- `clk` in 1: single clock. All state changes on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_byte` in 1: 1 = byte access, 0 = word access.
- `req_signed` in 1: byte load sign-extends when 1; ignored otherwise.
- `req_addr` in WORD*WIDTH: byte address.
- `req_wdata` in WORD*WIDTH: store data; byte store uses bits [WIDTH-1:0].
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_rdata` out WORD*WIDTH: load data; 0 for stores and faults.
- `rsp_fault` out 1: access rejected; RAM untouched.
- `ram_d` out WORD*WIDTH: RAM write data.
- `ram_ad` out WORD*WIDTH: RAM address.
- `ram_we` out 1: RAM write enable.
- `ram_q` in WORD*WIDTH: RAM registered read data. Byte at `ram_ad` is in bits [WIDTH-1:0].

## Operation
- States: IDLE, RD, WAIT, WR, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, capture all request fields and the fault flag.
  - Fault → RESP.
  - Word store → WR.
  - Otherwise → RD.
- **RD**: `ram_we`=0 and `ram_ad`=captured addr; → WAIT.
- **WAIT**: `ram_q` is valid.
  - Load: capture the result (word as-is; byte zero- or sign-extended from `ram_q[7:0]`) → RESP.
  - Byte store: capture merged word {`ram_q`[31:8], wdata[7:0]} → WR.
- **WR**: `ram_we`=1 for exactly one cycle, `ram_d`=store word; → RESP.
- **RESP**: `rsp_valid`=1, held with stable `rsp_rdata`/`rsp_fault` until `rsp_ready`; then → IDLE.
- Fault, checked at accept, is raised when either:
  - `req_addr`[31:ADDR_WIDTH] ≠ 0, or
  - `req_addr` > 2^ADDR_WIDTH − WORD (the word window would wrap).
  - This applies to byte accesses too: the last WORD−1 bytes are unreachable.
- Outside WR: `ram_we`=0 and `ram_d`=0. `ram_ad` always equals the captured address register.
- Unaligned word access is permitted: the RAM reads/writes any 4-byte window.

## Timing
- Accept edge = cycle 0. `rsp_valid` first asserts in:
  - fault: cycle 1
  - word store: cycle 2 (write at end of cycle 1)
  - load: cycle 3
  - byte store: cycle 4 (write at end of cycle 3)
- No new request is accepted until the response handshake completes; throughput is one request per latency+1 cycles minimum.
- Back-to-back: `rsp_ready` in the first RESP cycle returns the block to IDLE the next cycle.
- Outputs and state are registered, except `req_ready`, `rsp_valid` and `ram_we`, which decode directly from state.
- Reset values:
  - state IDLE
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0
  - `ram_we`=0, `ram_d`=0, `ram_ad`=0
- Reset mid-operation: the in-flight request is dropped with no response.
  - A WR cycle coincident with reset still commits its write, since the RAM samples `ram_we`=1 at that edge.
  - A byte store reset in RD/WAIT writes nothing.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined: a word access with `req_addr`[1:0] ≠ 0 is additionally a fault (latency 1, no RAM activity).
- Undefined: unaligned word accesses proceed normally.

## Structure
- `lsu_pkg`:
  - state enum `lsu_state_t`
  - request struct `lsu_req_t` (we, byte, signed, addr, wdata)
  - localparam for the fault bound 2^ADDR_WIDTH − WORD
- One sub-module, `lsu_byte_lane` (combinational):
  - byte extract + zero/sign extend for loads
  - byte merge for stores
- The FSM lives in the top module.

## Test plan
- Word store 0xDEADBEEF to 0x010, then word load 0x010 → `ram_we` pulses one cycle at cycle 1; load response 0xDEADBEEF at cycle 3.
- Memory 0x020..0x023 = 0x44332211; byte store 0xAB to 0x020 → RD, WAIT, WR with `ram_d`=0x443322AB; subsequent word load returns 0x443322AB.
- Byte load of 0x80 with `req_signed`=1 → 0xFFFFFF80; with `req_signed`=0 → 0x00000080.
- Request at 0x3FD (ADDR_WIDTH=10) and at 0x400 → `rsp_fault`=1 at cycle 1, `ram_we` never asserted. 0x3FC succeeds.
- Hold `rsp_ready`=0 for 5 cycles after a load → `rsp_valid`/`rsp_rdata` stable, `req_ready`=0, new `req_valid` ignored.
- Assert `reset` in WAIT of a byte store → no write to RAM, IDLE next cycle, `rsp_valid`=0. With `LSU_ALIGN_CHECK_EN`, a word load at 0x011 faults.
